updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised successor to the team's free-running 4-bit enable counter. Counts up or down with a programmable modulus, selectable wrap or saturate behaviour, a parallel load, an enable prescaler, and a terminal-count pulse with a sticky overflow flag. It serves as a reusable timing and event-count primitive behind the tile's dedicated I/O. All outputs are registered.

## Interface
- WIDTH, 8, count register width; legal range 2..16
- MAX_VAL, 2**WIDTH-1, highest count value; count range is 0..MAX_VAL; legal range 1..2**WIDTH-1
- PRESCALE, 1, enabled cycles per count step; legal range 1..256
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, synchronous, active-high
- clear  input  1  synchronous clear of count, prescaler and tc
- en  input  1  count enable; feeds the prescaler
- up_dn  input  1  direction: 1 = up, 0 = down
- sat_mode  input  1  1 = saturate at the limit, 0 = wrap modulo MAX_VAL+1
- load  input  1  parallel load strobe
- load_val  input  WIDTH  load value; values above MAX_VAL are clamped to MAX_VAL
- ovf_clr  input  1  clears the sticky ovf flag
- count  output  WIDTH  current count
- tc  output  1  one-cycle terminal-count pulse
- ovf  output  1  sticky overflow/underflow flag

## Operation
- Per-edge priority: rst > clear > load > step > hold.
- rst: count=0, prescaler=0, tc=0, ovf=0.
- clear: count=0, prescaler=0, tc=0. ovf is unchanged.
- load: count=min(load_val, MAX_VAL), prescaler=0, tc=0. ovf is unchanged. A step in the same cycle is discarded.
- Prescaler: an internal counter of width clog2(PRESCALE), minimum 1 bit.
  - It advances only on cycles with en=1.
  - A step event occurs on an en=1 cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - With PRESCALE=1, every en=1 cycle is a step.
  - With en=0, the prescaler holds its value (no reset).
- Terminal value: MAX_VAL when up_dn=1; 0 when up_dn=0. up_dn and sat_mode are sampled on the step cycle.
- Step when count is not at the terminal value: count±1, tc=0.
- Step when count is at the terminal value (terminal event):
  - wrap mode: count goes to 0 (up) or MAX_VAL (down).
  - saturate mode: count holds.
  - In both modes, tc=1 for the following cycle and ovf is set.
- Saturate mode at the limit: every further step is a terminal event, so tc re-pulses on each step and may stay high on consecutive cycles when PRESCALE=1.
- ovf: set by a terminal event, cleared by ovf_clr. Set wins when both occur in the same cycle.
- tc is 0 on any cycle that follows a non-step cycle.
- Arithmetic is unsigned, WIDTH bits. count never leaves the range 0..MAX_VAL.

## Timing
- count, tc and ovf update on the clock edge that processes the step, load, clear or rst. Latency from input to output is 1 cycle.
- No combinational path from any input to any output.
- Reset mid-count takes effect at the next edge, regardless of en, load or step state. Outputs read 0 in the following cycle.
- Changing up_dn mid-prescale does not reset the prescaler; the new direction applies at the next step.
- Reset values: count=0, tc=0, ovf=0.

## Test plan
Test parameters unless noted: WIDTH=4, MAX_VAL=9, PRESCALE=1.
- Reset then up-wrap: rst, then en=1, up_dn=1, sat_mode=0 for 12 cycles -> count reads 1..9, 0, 1, 2; tc=1 only in the cycle count reads 0; ovf=1 from that cycle on.
- Down-saturate: load load_val=2, then en=1, up_dn=0, sat_mode=1 for 5 cycles -> count reads 1, 0, 0, 0, 0; tc=1 in each of the last three cycles; ovf=1.
- Load clamp and priority: load=1, load_val=15, en=1 with count=3 -> count=9, tc=0; next cycle count+1 wraps to 0 with tc=1.
- Prescaler (PRESCALE=3): en=1 for 9 cycles, en=0 for 2 cycles, en=1 for 1 cycle -> count 0→3 after 9 cycles; count holds during the en=0 gap; count stays 3 after the single en=1 cycle, because the prescaler resumes from 0 and has not reached PRESCALE-1.
- ovf handling: ovf_clr=1 in the same cycle as a terminal event -> ovf stays 1; ovf_clr on a later cycle -> ovf=0. clear -> count=0 with ovf unchanged.
- Mid-operation reset: count=7, prescaler mid-cycle, load=1 and rst=1 together -> all outputs 0 in the next cycle; counting resumes from 0.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with prescaled enable, parallel load, wrap/saturate
// limit handling, a one-cycle terminal-count pulse and a sticky overflow flag.
module updown_mod_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    ps_q;
  logic [PW-1:0]    ps_d;
  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic             ovf_d;
  logic             step_c;
  logic             at_term_c;
  logic             term_evt_c;
  logic [WIDTH-1:0] load_clamp_c;

  // Step strobe and terminal detection for the current direction
  always_comb begin
    step_c       = en && (ps_q == PS_LAST);
    at_term_c    = up_dn ? (count == MAX_C) : (count == '0);
    load_clamp_c = (load_val > MAX_C) ? MAX_C : load_val;
    term_evt_c   = step_c && at_term_c && !clear && !load;
  end

  // Next-state for prescaler, count and tc; priority clear > load > step > hold
  always_comb begin
    ps_d    = ps_q;
    count_d = count;
    tc_d    = 1'b0;
    if (clear) begin
      ps_d    = '0;
      count_d = '0;
    end else if (load) begin
      ps_d    = '0;
      count_d = load_clamp_c;
    end else if (en) begin
      if (step_c) begin
        ps_d = '0;
        if (at_term_c) begin
          tc_d = 1'b1;
          if (!sat_mode) begin
            count_d = up_dn ? '0 : MAX_C;
          end
        end else begin
          count_d = up_dn ? (count + WIDTH'(1)) : (count - WIDTH'(1));
        end
      end else begin
        ps_d = ps_q + PW'(1);
      end
    end
  end

  // Sticky flag: a terminal event outranks a simultaneous clear request
  always_comb begin
    ovf_d = ovf;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (term_evt_c) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q  <= '0;
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      ps_q  <= ps_d;
      count <= count_d;
      tc    <= tc_d;
      ovf   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: instance a (MAX_VAL=9, PRESCALE=1), instance b (MAX_VAL=9, PRESCALE=3).
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst, clear, en, up_dn, sat_mode, load, ovf_clr;
  logic [3:0] load_val;
  logic [3:0] count_a, count_b;
  logic       tc_a, tc_b, ovf_a, ovf_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .en(en), .up_dn(up_dn),
    .sat_mode(sat_mode), .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
    .count(count_a), .tc(tc_a), .ovf(ovf_a)
  );

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .en(en), .up_dn(up_dn),
    .sat_mode(sat_mode), .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
    .count(count_b), .tc(tc_b), .ovf(ovf_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_cnt_dn[5] = '{1, 0, 0, 0, 0};
  int exp_tc_dn[5]  = '{0, 0, 1, 1, 1};

  initial begin
    rst = 1'b1; clear = 1'b0; en = 1'b0; up_dn = 1'b1; sat_mode = 1'b0;
    load = 1'b0; load_val = 4'd0; ovf_clr = 1'b0;
    tick();
    check("rst_count", int'(count_a), 0);
    check("rst_tc", int'(tc_a), 0);
    check("rst_ovf", int'(ovf_a), 0);
    check("rst_count_b", int'(count_b), 0);

    // Up-wrap over 12 cycles
    rst = 1'b0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("upwrap_count_%0d", i), int'(count_a), i % 10);
      check($sformatf("upwrap_tc_%0d", i), int'(tc_a), (i == 10) ? 1 : 0);
      check($sformatf("upwrap_ovf_%0d", i), int'(ovf_a), (i >= 10) ? 1 : 0);
    end

    // Down-saturate from a load of 2
    en = 1'b0; load = 1'b1; load_val = 4'd2;
    tick();
    check("dnsat_load", int'(count_a), 2);
    check("dnsat_load_tc", int'(tc_a), 0);
    load = 1'b0; en = 1'b1; up_dn = 1'b0; sat_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("dnsat_count_%0d", i), int'(count_a), exp_cnt_dn[i]);
      check($sformatf("dnsat_tc_%0d", i), int'(tc_a), exp_tc_dn[i]);
    end
    check("dnsat_ovf", int'(ovf_a), 1);

    // Load clamp beats a same-cycle step
    en = 1'b0; load = 1'b1; load_val = 4'd3; sat_mode = 1'b0;
    tick();
    check("clamp_pre", int'(count_a), 3);
    load_val = 4'd15; en = 1'b1; up_dn = 1'b1;
    tick();
    check("clamp_count", int'(count_a), 9);
    check("clamp_tc", int'(tc_a), 0);
    load = 1'b0;
    tick();
    check("clamp_wrap", int'(count_a), 0);
    check("clamp_wrap_tc", int'(tc_a), 1);

    // Sticky overflow: clear, then set-wins, then clear again
    en = 1'b0; ovf_clr = 1'b1;
    tick();
    check("ovf_cleared", int'(ovf_a), 0);
    check("ovf_cleared_tc", int'(tc_a), 0);
    en = 1'b1; up_dn = 1'b0;
    tick();
    check("ovf_setwins_count", int'(count_a), 9);
    check("ovf_setwins_tc", int'(tc_a), 1);
    check("ovf_setwins", int'(ovf_a), 1);
    en = 1'b0;
    tick();
    check("ovf_later_clr", int'(ovf_a), 0);
    check("ovf_later_tc", int'(tc_a), 0);
    ovf_clr = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick();
    check("ovf_reset_count", int'(count_a), 0);
    check("ovf_reset", int'(ovf_a), 1);
    en = 1'b0; load = 1'b1; load_val = 4'd5;
    tick();
    check("clear_pre", int'(count_a), 5);
    load = 1'b0; clear = 1'b1; en = 1'b1;
    tick();
    check("clear_count", int'(count_a), 0);
    check("clear_ovf", int'(ovf_a), 1);
    check("clear_tc", int'(tc_a), 0);
    clear = 1'b0; en = 1'b0;

    // Prescaler on instance b
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("ps_count_%0d", i), int'(count_b), i / 3);
    end
    check("ps_tc_after9", int'(tc_b), 0);
    en = 1'b0;
    tick();
    check("ps_gap1", int'(count_b), 3);
    tick();
    check("ps_gap2", int'(count_b), 3);
    en = 1'b1;
    tick();
    check("ps_resume", int'(count_b), 3);

    // Mid-operation reset beats load and step
    en = 1'b0; load = 1'b1; load_val = 4'd6;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    check("mid_pre_a", int'(count_a), 7);
    check("mid_pre_b", int'(count_b), 6);
    rst = 1'b1; load = 1'b1; load_val = 4'd8;
    tick();
    check("mid_rst_count", int'(count_a), 0);
    check("mid_rst_tc", int'(tc_a), 0);
    check("mid_rst_ovf", int'(ovf_a), 0);
    check("mid_rst_count_b", int'(count_b), 0);
    rst = 1'b0; load = 1'b0;
    tick();
    check("mid_resume_a", int'(count_a), 1);
    check("mid_resume_b1", int'(count_b), 0);
    tick();
    check("mid_resume_b2", int'(count_b), 0);
    tick();
    check("mid_resume_a3", int'(count_a), 3);
    check("mid_resume_b3", int'(count_b), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
